// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX bundle: decode-side fields (*_in) and
// registered execute-side fields (*_out).
//
// master: decode stage (drives *_in, sees *_out)
// slave : pipeline register (reads *_in, drives *_out)
interface id_ex_pipe_reg_if #(
  parameter int WORD_WIDTH            = 32,
  parameter int SHIFTER_OPERAND_WIDTH = 12,
  parameter int REG_ADDR_WIDTH        = 4,
  parameter int EXE_CMD_WIDTH         = 4,
  parameter int CTRL_WIDTH            = 5
);
  logic                             valid_in;
  logic [WORD_WIDTH-1:0]            pc_in;
  logic [CTRL_WIDTH-1:0]            ctrl_in;
  logic [EXE_CMD_WIDTH-1:0]         exe_cmd_in;
  logic [WORD_WIDTH-1:0]            val_rn_in;
  logic [WORD_WIDTH-1:0]            val_rm_in;
  logic                             imm_in;
  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_in;
  logic [23:0]                      signed_imm_24_in;
  logic [REG_ADDR_WIDTH-1:0]        dest_in;
  logic [3:0]                       status_in;

  logic                             valid_out;
  logic [WORD_WIDTH-1:0]            pc_out;
  logic [CTRL_WIDTH-1:0]            ctrl_out;
  logic [EXE_CMD_WIDTH-1:0]         exe_cmd_out;
  logic [WORD_WIDTH-1:0]            val_rn_out;
  logic [WORD_WIDTH-1:0]            val_rm_out;
  logic                             imm_out;
  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_out;
  logic [23:0]                      signed_imm_24_out;
  logic [REG_ADDR_WIDTH-1:0]        dest_out;
  logic [3:0]                       status_out;

  modport master (
    output valid_in, pc_in, ctrl_in, exe_cmd_in,
    output val_rn_in, val_rm_in, imm_in,
    output shifter_operand_in, signed_imm_24_in,
    output dest_in, status_in,
    input  valid_out, pc_out, ctrl_out, exe_cmd_out,
    input  val_rn_out, val_rm_out, imm_out,
    input  shifter_operand_out, signed_imm_24_out,
    input  dest_out, status_out
  );

  modport slave (
    input  valid_in, pc_in, ctrl_in, exe_cmd_in,
    input  val_rn_in, val_rm_in, imm_in,
    input  shifter_operand_in, signed_imm_24_in,
    input  dest_in, status_in,
    output valid_out, pc_out, ctrl_out, exe_cmd_out,
    output val_rn_out, val_rm_out, imm_out,
    output shifter_operand_out, signed_imm_24_out,
    output dest_out, status_out
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall and flush.
//
// clk    : rising-edge clock
// rst    : synchronous active-high reset
// flush  : branch taken in EX, load a bubble
// freeze : hazard stall, hold contents
// bus    : decode inputs / registered outputs
//          ctrl = {wb_en, mem_r_en, mem_w_en, b, s}
module id_ex_pipe_reg #(
  parameter int WORD_WIDTH            = 32,
  parameter int SHIFTER_OPERAND_WIDTH = 12,
  parameter int REG_ADDR_WIDTH        = 4,
  parameter int EXE_CMD_WIDTH         = 4,
  parameter int CTRL_WIDTH            = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          freeze,
  id_ex_pipe_reg_if.slave bus
);

  typedef struct packed {
    logic                             valid;
    logic [WORD_WIDTH-1:0]            pc;
    logic [CTRL_WIDTH-1:0]            ctrl;
    logic [EXE_CMD_WIDTH-1:0]         cmd;
    logic [WORD_WIDTH-1:0]            rn;
    logic [WORD_WIDTH-1:0]            rm;
    logic                             imm;
    logic [SHIFTER_OPERAND_WIDTH-1:0] sh;
    logic [23:0]                      simm;
    logic [REG_ADDR_WIDTH-1:0]        dest;
    logic [3:0]                       status;
  } ent_t;

  ent_t ent_q;
  ent_t ent_d;

  // Priority: flush over freeze over load.
  always_comb begin
    ent_d = ent_q;
    if (flush) begin
      ent_d = '0;
    end else if (!freeze) begin
      ent_d.valid  = bus.valid_in;
      ent_d.pc     = bus.pc_in;
      // An invalid slot must never write,
      // touch memory, branch or set flags.
      ent_d.ctrl   = bus.valid_in ?
                     bus.ctrl_in : '0;
      ent_d.cmd    = bus.exe_cmd_in;
      ent_d.rn     = bus.val_rn_in;
      ent_d.rm     = bus.val_rm_in;
      ent_d.imm    = bus.imm_in;
      ent_d.sh     = bus.shifter_operand_in;
      ent_d.simm   = bus.signed_imm_24_in;
      ent_d.dest   = bus.dest_in;
      ent_d.status = bus.status_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ent_q <= '0;
    else     ent_q <= ent_d;
  end

  assign bus.valid_out           = ent_q.valid;
  assign bus.pc_out              = ent_q.pc;
  assign bus.ctrl_out            = ent_q.ctrl;
  assign bus.exe_cmd_out         = ent_q.cmd;
  assign bus.val_rn_out          = ent_q.rn;
  assign bus.val_rm_out          = ent_q.rm;
  assign bus.imm_out             = ent_q.imm;
  assign bus.shifter_operand_out = ent_q.sh;
  assign bus.signed_imm_24_out   = ent_q.simm;
  assign bus.dest_out            = ent_q.dest;
  assign bus.status_out          = ent_q.status;

endmodule
